dds_phase_acc_b: RTL and testbench

- B-channel DDS phase accumulator that sits directly upstream of the B-channel waveform ROM/select stage and drives its 10-bit ROM address.
- Captures frequency, phase-offset and control words from the STM32 parallel bus synchronously, with no latches.
- Advances a 32-bit phase accumulator every clock.
- Emits a registered 10-bit ROM address and a once-per-cycle wrap pulse.

---
 rtl/dds_phase_acc_b.sv | 91 +++++++++
 tb/tb_dds_phase_acc_b.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_acc_b.sv
// B-channel DDS phase accumulator: bus-programmed tuning word, phase offset and
// RUN/CLR control, producing a registered 10-bit ROM address and a wrap pulse.
module dds_phase_acc_b #(
    parameter logic [15:0] ADDR_FREQ_L = 16'h000D,
    parameter logic [15:0] ADDR_FREQ_H = 16'h000E,
    parameter logic [15:0] ADDR_PHASE  = 16'h000F,
    parameter logic [15:0] ADDR_CTRL   = 16'h0010
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CS,
    input  logic        WR_EN,
    input  logic [15:0] ADDR,
    input  logic [15:0] DATA,
    output logic [9:0]  addr_b,
    output logic        wrap_b,
    output logic        run_b
);

    logic        r_wr_hit_d;
    logic [15:0] r_freq_shadow_l;
    logic [31:0] r_freq_act;
    logic [9:0]  r_phase_off;
    logic        r_run;
    logic [31:0] r_acc;
    logic        r_carry;

    logic        w_wr_hit;
    logic        w_wr_pulse;
    logic        w_clr;
    logic [32:0] w_sum;
    logic        w_carry;
    logic [31:0] w_acc_next;

    // A held strobe is decoded only on its first cycle.
    assign w_wr_hit   = !CS && WR_EN;
    assign w_wr_pulse = w_wr_hit && !r_wr_hit_d;
    assign w_clr      = w_wr_pulse && (ADDR == ADDR_CTRL) && DATA[1];

    assign w_sum   = {1'b0, r_acc} + {1'b0, r_freq_act};
    assign w_carry = r_run && !w_clr && w_sum[32];

    always_comb begin
        w_acc_next = r_acc;
        if (w_clr) begin
            w_acc_next = 32'd0;
        end else if (r_run) begin
            w_acc_next = w_sum[31:0];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_hit_d      <= 1'b0;
            r_freq_shadow_l <= 16'd0;
            r_freq_act      <= 32'd0;
            r_phase_off     <= 10'd0;
            r_run           <= 1'b0;
        end else begin
            r_wr_hit_d <= w_wr_hit;
            if (w_wr_pulse) begin
                case (ADDR)
                    ADDR_FREQ_L: r_freq_shadow_l <= DATA;
                    // Both halves land in one edge, so the accumulator never sees a torn word.
                    ADDR_FREQ_H: r_freq_act      <= {DATA, r_freq_shadow_l};
                    ADDR_PHASE:  r_phase_off     <= DATA[9:0];
                    ADDR_CTRL:   r_run           <= DATA[0];
                    default:     ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_acc   <= 32'd0;
            r_carry <= 1'b0;
            addr_b  <= 10'd0;
            wrap_b  <= 1'b0;
        end else begin
            r_acc   <= w_acc_next;
            r_carry <= w_carry;
            addr_b  <= r_acc[31:22] + r_phase_off;
            // Carry is held one extra edge so the pulse meets the first post-wrap address.
            wrap_b  <= r_carry;
        end
    end

    assign run_b = r_run;

endmodule

// File: tb/tb_dds_phase_acc_b.sv
// Self-checking bench for dds_phase_acc_b: arithmetic reference model compared
// every cycle, plus directed literal expectations for the key scenarios.
module tb_dds_phase_acc_b;

    localparam logic [15:0] A_FL = 16'h000D;
    localparam logic [15:0] A_FH = 16'h000E;
    localparam logic [15:0] A_PH = 16'h000F;
    localparam logic [15:0] A_CT = 16'h0010;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        CS;
    logic        WR_EN;
    logic [15:0] ADDR;
    logic [15:0] DATA;
    logic [9:0]  addr_b;
    logic        wrap_b;
    logic        run_b;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    dds_phase_acc_b dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .CS     (CS),
        .WR_EN  (WR_EN),
        .ADDR   (ADDR),
        .DATA   (DATA),
        .addr_b (addr_b),
        .wrap_b (wrap_b),
        .run_b  (run_b)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase as a plain integer, outputs derived from the phase
    // and offset that held before each edge.
    longint unsigned m_acc, m_freq, m_sum, m_step;
    bit [15:0] m_shadow;
    bit [9:0]  m_phase;
    bit        m_run, m_prev_strobe, m_wrap_pend;
    bit [9:0]  exp_addr;
    bit        exp_wrap;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_acc = 0; m_freq = 0; m_shadow = 0; m_phase = 0;
            m_run = 0; m_prev_strobe = 0; m_wrap_pend = 0;
            exp_addr = 0; exp_wrap = 0;
        end else begin
            bit strobe, first, clear;
            strobe   = !CS && WR_EN;
            first    = strobe && !m_prev_strobe;
            clear    = first && ADDR == A_CT && DATA[1];
            exp_addr = 10'(((m_acc / 64'd4194304) + m_phase) % 1024);
            exp_wrap = m_wrap_pend;
            m_step   = m_run ? m_freq : 0;
            m_sum    = m_acc + m_step;
            if (clear) begin
                m_acc = 0;
                m_wrap_pend = 0;
            end else begin
                m_acc = m_sum % 64'h1_0000_0000;
                m_wrap_pend = (m_sum >= 64'h1_0000_0000);
            end
            if (first) begin
                if (ADDR == A_FL) m_shadow = DATA;
                if (ADDR == A_FH) m_freq = longint'(DATA) * 65536 + longint'(m_shadow);
                if (ADDR == A_PH) m_phase = DATA[9:0];
                if (ADDR == A_CT) m_run = DATA[0];
            end
            m_prev_strobe = strobe;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("model_addr_b", 32'(addr_b), 32'(exp_addr));
            check("model_wrap_b", 32'(wrap_b), 32'(exp_wrap));
            check("model_run_b",  32'(run_b),  32'(m_run));
        end
    end

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge CLK);
        CS = 1'b0; WR_EN = 1'b1; ADDR = a; DATA = d;
        @(negedge CLK);
        CS = 1'b1; WR_EN = 1'b0; ADDR = 16'h0000; DATA = 16'h0000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        logic [9:0] a0, a1;
        logic [9:0] samp [1:6];
        int wraps;

        RST_N = 1'b0; CS = 1'b1; WR_EN = 1'b0; ADDR = 16'h0; DATA = 16'h0;
        idle(3);
        check("reset_addr_b", 32'(addr_b), 32'd0);
        check("reset_wrap_b", 32'(wrap_b), 32'd0);
        check("reset_run_b",  32'(run_b),  32'd0);
        RST_N = 1'b1;
        chk_en = 1'b1;
        idle(3);
        check("idle_addr_b", 32'(addr_b), 32'd0);

        // Step of one address per cycle: exactly one wrap, landing on address 0.
        bus_write(A_FL, 16'h0000);
        bus_write(A_FH, 16'h0040);
        bus_write(A_CT, 16'h0001);
        check("run_on", 32'(run_b), 32'd1);
        wraps = 0;
        for (int k = 0; k < 1100; k++) begin
            @(negedge CLK);
            if (wrap_b) begin
                wraps++;
                check("wrap_at_zero", 32'(addr_b), 32'd0);
            end
        end
        check("wrap_count", 32'(wraps), 32'd1);

        // Low half alone must not change the step; the high half commits step 2.
        bus_write(A_FL, 16'h0000);
        idle(3);
        a0 = addr_b; @(negedge CLK); a1 = addr_b;
        check("step_after_low", 32'(10'(a1 - a0)), 32'd1);
        bus_write(A_FH, 16'h0080);
        idle(4);
        a0 = addr_b; @(negedge CLK); a1 = addr_b;
        check("step_after_high", 32'(10'(a1 - a0)), 32'd2);

        // Phase offset latency with a frozen, cleared accumulator.
        bus_write(A_FH, 16'h0000);
        bus_write(A_CT, 16'h0003);
        bus_write(A_PH, 16'h0200);
        check("phase_not_yet", 32'(addr_b), 32'd0);
        @(negedge CLK);
        check("phase_512", 32'(addr_b), 32'd512);

        // Park acc[31:22] at 2, then offset 0x3FF wraps the address to 1.
        bus_write(A_FH, 16'h0040);
        bus_write(A_CT, 16'h0003);
        bus_write(A_CT, 16'h0000);
        bus_write(A_FH, 16'h0000);
        bus_write(A_CT, 16'h0001);
        bus_write(A_PH, 16'h03FF);
        @(negedge CLK);
        check("phase_mod", 32'(addr_b), 32'd1);

        // Held CLR+RUN strobe clears once, then counting resumes under the strobe.
        bus_write(A_PH, 16'h0000);
        bus_write(A_FH, 16'h0040);
        idle(20);
        @(negedge CLK);
        CS = 1'b0; WR_EN = 1'b1; ADDR = A_CT; DATA = 16'h0003;
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            samp[k] = addr_b;
        end
        CS = 1'b1; WR_EN = 1'b0; ADDR = 16'h0; DATA = 16'h0;
        for (int k = 2; k <= 6; k++)
            check("held_clr_seq", 32'(samp[k]), 32'(k - 2));

        // Asynchronous reset between edges clears outputs without a clock edge.
        idle(10);
        #2 RST_N = 1'b0;
        #1;
        check("async_addr_b", 32'(addr_b), 32'd0);
        check("async_wrap_b", 32'(wrap_b), 32'd0);
        check("async_run_b",  32'(run_b),  32'd0);
        idle(2);
        RST_N = 1'b1;
        idle(20);
        check("post_reset_addr_b", 32'(addr_b), 32'd0);
        check("post_reset_run_b",  32'(run_b),  32'd0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
